key_move_decoder: RTL and testbench

//  Converts PS/2 Set-2 scancode bytes from the keyboard receiver into level-held

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/key_move_decoder.sv | 187 ++++++++++++++++++
 tb/tb_key_move_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types for the keyboard movement decoder: scancode parser states,
// movement direction and the Set-2 prefix bytes.
package kbd_pkg;

    typedef enum logic [1:0] {
        K_IDLE,
        K_E0,
        K_BRK,
        K_E0BRK
    } KbdState;

    typedef enum logic [1:0] {
        NONE,
        LEFT,
        RIGHT
    } Dir;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

endpackage : kbd_pkg

// File: rtl/key_move_decoder.sv
// Turns PS/2 Set-2 scancode bytes into level-held left/right/action commands.
// Each direction can be held from two keys (letter and arrow). When both
// directions are held, the one pressed most recently drives the output.
module key_move_decoder
    import kbd_pkg::*;
#(
    parameter logic [7:0] LEFT_CODE      = 8'h1C,
    parameter logic [7:0] RIGHT_CODE     = 8'h23,
    parameter logic [7:0] ACT_CODE       = 8'h29,
    parameter logic [7:0] LEFT_EXT_CODE  = 8'h6B,
    parameter logic [7:0] RIGHT_EXT_CODE = 8'h74,
    parameter int unsigned PREFIX_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       m_left,
    output logic       m_right,
    output logic       button_pressed
);

    localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    KbdState          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-source held flags: letter key and arrow key for each direction.
    logic la_q, la_d;
    logic lr_q, lr_d;
    logic ra_q, ra_d;
    logic rr_q, rr_d;
    logic act_q, act_d;
    Dir   last_dir_q, last_dir_d;

    logic m_left_q, m_left_d;
    logic m_right_q, m_right_d;
    logic button_q, button_d;

    // Decoded key event for the byte completing a sequence this cycle.
    logic ev_valid;
    logic ev_make;
    logic ev_ext;
    logic hit_la, hit_lr, hit_ra, hit_rr, hit_act;
    logic left_held_d, right_held_d;

    // Parser state and prefix-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= K_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Held-key bookkeeping and registered movement outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            la_q       <= 1'b0;
            lr_q       <= 1'b0;
            ra_q       <= 1'b0;
            rr_q       <= 1'b0;
            act_q      <= 1'b0;
            last_dir_q <= NONE;
            m_left_q   <= 1'b0;
            m_right_q  <= 1'b0;
            button_q   <= 1'b0;
        end else begin
            la_q       <= la_d;
            lr_q       <= lr_d;
            ra_q       <= ra_d;
            rr_q       <= rr_d;
            act_q      <= act_d;
            last_dir_q <= last_dir_d;
            m_left_q   <= m_left_d;
            m_right_q  <= m_right_d;
            button_q   <= button_d;
        end
    end

    // Next-state: byte parsing, timeout, key matching, held flags, arbitration.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ev_valid = 1'b0;
        ev_make  = 1'b0;
        ev_ext   = 1'b0;

        if (rx_valid) begin
            cnt_d = '0;
            unique case (state_q)
                K_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_d = K_E0;
                    end else if (rx_data == SC_BRK) begin
                        state_d = K_BRK;
                    end else begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                    end
                end
                K_E0: begin
                    if (rx_data == SC_BRK) begin
                        state_d = K_E0BRK;
                    end else begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = K_IDLE;
                    end
                end
                K_BRK: begin
                    ev_valid = 1'b1;
                    state_d  = K_IDLE;
                end
                K_E0BRK: begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = K_IDLE;
                end
                default: state_d = K_IDLE;
            endcase
        end else if (state_q != K_IDLE) begin
            // A lost byte must not leave the parser stuck behind a prefix.
            if (cnt_q == CNT_LAST) begin
                state_d = K_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        hit_la  = ev_valid && !ev_ext && (rx_data == LEFT_CODE);
        hit_ra  = ev_valid && !ev_ext && (rx_data == RIGHT_CODE);
        hit_act = ev_valid && !ev_ext && (rx_data == ACT_CODE);
        hit_lr  = ev_valid &&  ev_ext && (rx_data == LEFT_EXT_CODE);
        hit_rr  = ev_valid &&  ev_ext && (rx_data == RIGHT_EXT_CODE);

        la_d       = la_q;
        lr_d       = lr_q;
        ra_d       = ra_q;
        rr_d       = rr_q;
        act_d      = act_q;
        last_dir_d = last_dir_q;

        if (ev_make) begin
            // Only a fresh press of a direction claims priority; repeats do not.
            if ((hit_la || hit_lr) && !(la_q || lr_q)) last_dir_d = LEFT;
            if ((hit_ra || hit_rr) && !(ra_q || rr_q)) last_dir_d = RIGHT;
            if (hit_la)  la_d  = 1'b1;
            if (hit_lr)  lr_d  = 1'b1;
            if (hit_ra)  ra_d  = 1'b1;
            if (hit_rr)  rr_d  = 1'b1;
            if (hit_act) act_d = 1'b1;
        end else begin
            if (hit_la)  la_d  = 1'b0;
            if (hit_lr)  lr_d  = 1'b0;
            if (hit_ra)  ra_d  = 1'b0;
            if (hit_rr)  rr_d  = 1'b0;
            if (hit_act) act_d = 1'b0;
        end

        left_held_d  = la_d | lr_d;
        right_held_d = ra_d | rr_d;

        // Priority falls back to the other direction once the winner is released.
        if (last_dir_d == LEFT && !left_held_d) begin
            last_dir_d = right_held_d ? RIGHT : NONE;
        end else if (last_dir_d == RIGHT && !right_held_d) begin
            last_dir_d = left_held_d ? LEFT : NONE;
        end

        m_left_d  = left_held_d  && (!right_held_d || last_dir_d == LEFT);
        m_right_d = right_held_d && (!left_held_d  || last_dir_d == RIGHT);
        button_d  = act_d;
    end

    assign m_left         = m_left_q;
    assign m_right        = m_right_q;
    assign button_pressed = button_q;

endmodule : key_move_decoder

// File: tb/tb_key_move_decoder.sv
// Bench for key_move_decoder: directed scancode sequences, a timestamp-based
// reference model compared every cycle, plus literal expectations.
module tb_key_move_decoder;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       m_left, m_right, button_pressed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_move_decoder #(
        .LEFT_CODE      (8'h1C),
        .RIGHT_CODE     (8'h23),
        .ACT_CODE       (8'h29),
        .LEFT_EXT_CODE  (8'h6B),
        .RIGHT_EXT_CODE (8'h74),
        .PREFIX_TIMEOUT (P)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .m_left         (m_left),
        .m_right        (m_right),
        .button_pressed (button_pressed)
    );

    // Reference model: held state per physical key, the cycle each direction
    // became held, and pending prefixes with the cycle of the last byte.
    int  cyc = 0;
    int  last_cyc = 0;
    int  t_left = 0, t_right = 0;
    bit  k_a = 0, k_la = 0, k_d = 0, k_ra = 0, k_sp = 0;
    bit  pend_e0 = 0, pend_brk = 0;
    bit  e_left = 0, e_right = 0, e_btn = 0;
    bit  started = 0;

    always @(posedge clk) begin
        bit ext, make, lh, rh;
        cyc++;
        if (rst) begin
            k_a = 0; k_la = 0; k_d = 0; k_ra = 0; k_sp = 0;
            pend_e0 = 0; pend_brk = 0;
            started = 1;
        end else if (rx_valid) begin
            if ((pend_e0 || pend_brk) && (cyc - last_cyc > P)) begin
                pend_e0 = 0;
                pend_brk = 0;
            end
            last_cyc = cyc;
            if (rx_data == 8'hE0 && !pend_e0 && !pend_brk) begin
                pend_e0 = 1;
            end else if (rx_data == 8'hF0 && !pend_brk) begin
                pend_brk = 1;
            end else begin
                ext  = pend_e0;
                make = !pend_brk;
                pend_e0 = 0;
                pend_brk = 0;
                lh = k_a | k_la;
                rh = k_d | k_ra;
                if (make && !lh && ((!ext && rx_data == 8'h1C) || (ext && rx_data == 8'h6B))) t_left = cyc;
                if (make && !rh && ((!ext && rx_data == 8'h23) || (ext && rx_data == 8'h74))) t_right = cyc;
                if (!ext && rx_data == 8'h1C) k_a  = make;
                if ( ext && rx_data == 8'h6B) k_la = make;
                if (!ext && rx_data == 8'h23) k_d  = make;
                if ( ext && rx_data == 8'h74) k_ra = make;
                if (!ext && rx_data == 8'h29) k_sp = make;
            end
        end
        lh = k_a | k_la;
        rh = k_d | k_ra;
        e_left  = lh && (!rh || t_left > t_right);
        e_right = rh && (!lh || t_right > t_left);
        e_btn   = k_sp;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (m_left !== e_left || m_right !== e_right || button_pressed !== e_btn) begin
                errors++;
                $display("FAIL model t=%0t: got L/R/B=%b%b%b expected %b%b%b",
                         $time, m_left, m_right, button_pressed, e_left, e_right, e_btn);
            end
            checks++;
            if (m_left === 1'b1 && m_right === 1'b1) begin
                errors++;
                $display("FAIL exclusive t=%0t: m_left and m_right both 1", $time);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect3(input string name, input logic l, input logic r, input logic b);
        checks++;
        if (m_left !== l || m_right !== r || button_pressed !== b) begin
            errors++;
            $display("FAIL %s: got L/R/B=%b%b%b expected %b%b%b",
                     name, m_left, m_right, button_pressed, l, r, b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        expect3("reset", 0, 0, 0);

        // Plain make/break of left.
        send(8'h1C);            expect3("left_make", 1, 0, 0);
        send(8'hF0); send(8'h1C); expect3("left_break", 0, 0, 0);
        idle(2);

        // Most recent direction wins, then falls back.
        send(8'h1C); send(8'h23); expect3("both_right_newer", 0, 1, 0);
        send(8'hF0); send(8'h23); expect3("right_released", 1, 0, 0);
        send(8'h23);              expect3("right_again", 0, 1, 0);
        send(8'h1C);              expect3("left_repeat", 0, 1, 0);
        send(8'hF0); send(8'h1C); expect3("left_released", 0, 1, 0);
        send(8'hF0); send(8'h23); expect3("all_released", 0, 0, 0);
        idle(3);

        // Extended right arrow; non-extended break does not release it.
        send(8'hE0); send(8'h74); expect3("arrow_make", 0, 1, 0);
        send(8'hF0); send(8'h74); expect3("nonext_break", 0, 1, 0);
        send(8'hE0); send(8'hF0); send(8'h74); expect3("arrow_break", 0, 0, 0);
        idle(2);

        // Typematic repeat of the action key.
        for (int i = 0; i < 5; i++) begin
            send(8'h29);
            expect3("act_repeat", 0, 0, 1);
        end
        send(8'hF0); send(8'h29); expect3("act_break", 0, 0, 0);
        idle(2);

        // Prefix expires after P quiet cycles: next byte is non-extended.
        send(8'hE0); idle(P); send(8'h1C); expect3("timeout_nonext", 1, 0, 0);
        send(8'hF0); send(8'h1C); expect3("timeout_cleanup", 0, 0, 0);
        // One cycle short of expiry the prefix still applies.
        send(8'hE0); idle(P - 1); send(8'h74); expect3("timeout_edge_ext", 0, 1, 0);
        send(8'hE0); send(8'hF0); idle(P - 1); send(8'h74); expect3("timeout_edge_brk", 0, 0, 0);
        idle(2);

        // Two sources for left.
        send(8'h1C); send(8'hE0); send(8'h6B); expect3("two_left_srcs", 1, 0, 0);
        send(8'hF0); send(8'h1C);              expect3("one_left_src_left", 1, 0, 0);
        send(8'hE0); send(8'hF0); send(8'h6B); expect3("left_src_gone", 0, 0, 0);

        // Reset mid-sequence drops the pending break.
        send(8'h1C); send(8'h29); expect3("pre_rst", 1, 0, 1);
        send(8'hE0); send(8'hF0);
        do_reset();              expect3("mid_seq_rst", 0, 0, 0);
        send(8'h6B);             expect3("post_rst_6b", 0, 0, 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_move_decoder
